rr_arbiter: RTL

- Round-robin arbiter that shares one resource slot among 2**N_IN requesters.
- The grant is produced both as a one-hot vector, in the same format as the decoder output, and as a binary index.
- Ownership is lock-until-release: the owner keeps the grant while it holds its request.
- Sits in front of the decoder-indexed resource and schedules which requester drives it.

---
 rtl/rr_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with lock-until-release ownership, one-hot + binary grant.
// Optional owner preemption after MAX_HOLD hold cycles is enabled by ARB_TIMEOUT_EN.
module rr_arbiter #(
  parameter int N_IN     = 3,
  parameter int OUT      = 2**N_IN,
  parameter int MAX_HOLD = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OUT-1:0]  req,
  output logic [OUT-1:0]  grant,
  output logic [N_IN-1:0] grant_id,
  output logic            grant_valid,
  output logic            preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  // Elaboration-time guards on the configuration.
  if (OUT != 2**N_IN) begin : g_bad_out
    $error("rr_arbiter: OUT must equal 2**N_IN");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("rr_arbiter: MAX_HOLD must be in 1..255");
  end

  state_t          state, state_n;
  logic [N_IN-1:0] ptr, ptr_n;
  logic [OUT-1:0]  grant_n;
  logic [N_IN-1:0] grant_id_n;
  logic            grant_valid_n;
  logic            preempt_n;
  logic [OUT-1:0]  cand;
  logic [N_IN-1:0] win;
  logic            any_cand;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hcnt, hcnt_n;
  logic       hold_expired;
`endif

  // First set bit of cand scanning upward from start, wrapping at OUT-1.
  function automatic logic [N_IN-1:0] find_winner(input logic [OUT-1:0]  c,
                                                  input logic [N_IN-1:0] start);
    logic [N_IN-1:0] idx;
    logic [N_IN-1:0] best;
    logic            found;
    best  = '0;
    found = 1'b0;
    for (int i = 0; i < OUT; i++) begin
      idx = start + N_IN'(i);
      if (!found && c[idx]) begin
        best  = idx;
        found = 1'b1;
      end
    end
    return best;
  endfunction

  // The current owner never competes against itself, so a release or a
  // preemption always hands the slot to someone else.
  always_comb begin
    cand = req;
    if (state == GRANT) cand[grant_id] = 1'b0;
  end

  assign any_cand = |cand;
  assign win      = find_winner(cand, ptr);

`ifdef ARB_TIMEOUT_EN
  assign hold_expired = (hcnt == 8'(MAX_HOLD));
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_n       = state;
    ptr_n         = ptr;
    grant_n       = grant;
    grant_id_n    = grant_id;
    grant_valid_n = grant_valid;
    preempt_n     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hcnt_n        = hcnt;
`endif

    unique case (state)
      IDLE: begin
        if (any_cand) begin
          state_n       = GRANT;
          grant_n       = OUT'(1) << win;
          grant_id_n    = win;
          grant_valid_n = 1'b1;
          ptr_n         = win + N_IN'(1);
`ifdef ARB_TIMEOUT_EN
          hcnt_n        = '0;
`endif
        end
      end

      GRANT: begin
        if (req[grant_id]) begin
`ifdef ARB_TIMEOUT_EN
          if (hold_expired && any_cand) begin
            grant_n    = OUT'(1) << win;
            grant_id_n = win;
            ptr_n      = win + N_IN'(1);
            hcnt_n     = '0;
            preempt_n  = 1'b1;
          end else if (!hold_expired) begin
            hcnt_n = hcnt + 8'd1;
          end
`endif
        end else if (any_cand) begin
          // Release with others waiting: hand over on this edge, no idle gap.
          grant_n    = OUT'(1) << win;
          grant_id_n = win;
          ptr_n      = win + N_IN'(1);
`ifdef ARB_TIMEOUT_EN
          hcnt_n     = '0;
`endif
        end else begin
          // grant_id and ptr deliberately keep their values across idle.
          state_n       = IDLE;
          grant_n       = '0;
          grant_valid_n = 1'b0;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      preempt     <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      grant       <= grant_n;
      grant_id    <= grant_id_n;
      grant_valid <= grant_valid_n;
      preempt     <= preempt_n;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) hcnt <= '0;
    else     hcnt <= hcnt_n;
  end
`else
  // Without the timeout feature preempt_n is constant 0, so preempt stays 0.
`endif

endmodule
